// File: rtl/iob_cache_read_channel_axi_pkg.sv
// Shared definitions for the cache AXI read channel.
//  - rd_state_t  : line-fill FSM states
//  - AXI_*       : fixed AXI encodings (INCR burst, cache attributes, OKAY)
//  - line2be_w() : log2 of back-end beats per cache line
//  - beat_idx_w(): width of the beat index port (at least 1 bit)
package iob_cache_read_channel_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_CACHE_RD   = 4'b0011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic int line2be_w(input int word_offset_w, input int fe_data_w,
                                    input int be_data_w);
      return word_offset_w - $clog2(be_data_w / fe_data_w);
   endfunction

   function automatic int beat_idx_w(input int word_offset_w, input int fe_data_w,
                                     input int be_data_w);
      int w;
      w = line2be_w(word_offset_w, fe_data_w, be_data_w);
      return (w > 0) ? w : 1;
   endfunction

endpackage

// File: rtl/iob_cache_read_channel_axi.sv
// AXI4 read-channel master for the cache back-end.
// On a replacement request it fetches the whole line with one INCR burst and
// streams every returned beat to the data memory together with its index.
// A burst that returned any non-OKAY response is re-fetched from scratch.
//
// Ports:
//  clk_i, reset_n        clock, asynchronous active-low reset
//  replace_valid_i/addr  line-fill request and line address
//  replace_o             fill in progress
//  read_valid_o/addr/rdata  data-memory write port (one per R beat)
//  axi_ar*               AR channel (single burst descriptor)
//  axi_r*                R channel (rid ignored)
module iob_cache_read_channel_axi
   import iob_cache_read_channel_axi_pkg::*;
#(
   parameter int FE_ADDR_W     = 24,
   parameter int FE_DATA_W     = 32,
   parameter int BE_ADDR_W     = 24,
   parameter int BE_DATA_W     = 32,
   parameter int WORD_OFFSET_W = 3,
   parameter int AXI_ID_W      = 1,
   parameter int AXI_ID        = 0,
   parameter int AXI_LEN_W     = 8
) (
   input  logic                                          clk_i,
   input  logic                                          reset_n,
   input  logic                                          replace_valid_i,
   input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-WORD_OFFSET_W-1:0] replace_addr_i,
   output logic                                          replace_o,
   output logic                                          read_valid_o,
   output logic [beat_idx_w(WORD_OFFSET_W, FE_DATA_W, BE_DATA_W)-1:0] read_addr_o,
   output logic [BE_DATA_W-1:0]                          read_rdata_o,
   output logic                                          axi_arvalid_o,
   input  logic                                          axi_arready_i,
   output logic [BE_ADDR_W-1:0]                          axi_araddr_o,
   output logic [AXI_ID_W-1:0]                           axi_arid_o,
   output logic [AXI_LEN_W-1:0]                          axi_arlen_o,
   output logic [2:0]                                    axi_arsize_o,
   output logic [1:0]                                    axi_arburst_o,
   output logic                                          axi_arlock_o,
   output logic [3:0]                                    axi_arcache_o,
   output logic [2:0]                                    axi_arprot_o,
   output logic [3:0]                                    axi_arqos_o,
   input  logic                                          axi_rvalid_i,
   output logic                                          axi_rready_o,
   input  logic [BE_DATA_W-1:0]                          axi_rdata_i,
   input  logic [1:0]                                    axi_rresp_i,
   input  logic                                          axi_rlast_i,
   input  logic [AXI_ID_W-1:0]                           axi_rid_i
);

   localparam int FE_NBYTES_W = $clog2(FE_DATA_W / 8);
   localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8);
   localparam int LINE2BE_W   = line2be_w(WORD_OFFSET_W, FE_DATA_W, BE_DATA_W);
   localparam int CNT_W       = beat_idx_w(WORD_OFFSET_W, FE_DATA_W, BE_DATA_W);
   localparam int LADDR_W     = FE_ADDR_W - FE_NBYTES_W - WORD_OFFSET_W;
   localparam int OFFS_W      = FE_NBYTES_W + WORD_OFFSET_W;
   localparam int EXT_W       = (FE_ADDR_W > BE_ADDR_W) ? FE_ADDR_W : BE_ADDR_W;

   rd_state_t          state_q, state_d;
   logic [LADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               beat;
   logic               beat_err;
   logic [EXT_W-1:0]   araddr_ext;
   logic               unused_rid;

   // Beat accepted this cycle, and the sticky error including this beat.
   assign beat     = (state_q == ST_DATA) && axi_rvalid_i;
   assign beat_err = err_q || (axi_rresp_i != AXI_RESP_OKAY);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (replace_valid_i) begin
               addr_d  = replace_addr_i;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (axi_arready_i) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (axi_rvalid_i) begin
               // Counter wraps naturally; rlast alone ends the burst.
               cnt_d = cnt_q + CNT_W'(1);
               err_d = beat_err;
               if (axi_rlast_i) begin
                  if (beat_err) begin
                     // Corrupted line: fetch it again from the first beat.
                     cnt_d   = '0;
                     err_d   = 1'b0;
                     state_d = ST_ADDR;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign replace_o     = (state_q != ST_IDLE);
   assign axi_arvalid_o = (state_q == ST_ADDR);
   assign axi_rready_o  = (state_q == ST_DATA);

   assign read_valid_o  = beat;
   assign read_addr_o   = (LINE2BE_W > 0) ? cnt_q : '0;
   assign read_rdata_o  = beat ? axi_rdata_i : '0;

   // Line base address, then zero-extended or truncated to the AXI width.
   assign araddr_ext    = EXT_W'({addr_q, {OFFS_W{1'b0}}});
   assign axi_araddr_o  = araddr_ext[BE_ADDR_W-1:0];

   assign axi_arid_o    = AXI_ID_W'(AXI_ID);
   assign axi_arlen_o   = AXI_LEN_W'((1 << LINE2BE_W) - 1);
   assign axi_arsize_o  = 3'(BE_NBYTES_W);
   assign axi_arburst_o = AXI_BURST_INCR;
   assign axi_arlock_o  = 1'b0;
   assign axi_arcache_o = AXI_CACHE_RD;
   assign axi_arprot_o  = 3'b000;
   assign axi_arqos_o   = 4'b0000;

   assign unused_rid    = ^axi_rid_i;

endmodule

// File: tb/tb_iob_cache_read_channel_axi.sv
module tb_iob_cache_read_channel_axi;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // default-parameter DUT (8 beats per line)
   logic        req, replace, rd_valid, arvalid, arready, arlock, rvalid, rready, rlast;
   logic [18:0] raddr;
   logic [2:0]  rd_addr, arsize, arprot;
   logic [31:0] rd_data, rdata;
   logic [23:0] araddr;
   logic [0:0]  arid, rid;
   logic [7:0]  arlen;
   logic [1:0]  arburst, rresp;
   logic [3:0]  arcache, arqos;

   // wide DUT: one 256-bit beat per line
   logic         w_req, w_replace, w_rd_valid, w_arvalid, w_arready, w_arlock, w_rvalid, w_rready, w_rlast;
   logic [18:0]  w_raddr;
   logic [0:0]   w_rd_addr, w_arid, w_rid;
   logic [2:0]   w_arsize, w_arprot;
   logic [255:0] w_rd_data, w_rdata;
   logic [23:0]  w_araddr;
   logic [7:0]   w_arlen;
   logic [1:0]   w_arburst, w_rresp;
   logic [3:0]   w_arcache, w_arqos;

   iob_cache_read_channel_axi dut (
      .clk_i(clk), .reset_n(rst_n),
      .replace_valid_i(req), .replace_addr_i(raddr), .replace_o(replace),
      .read_valid_o(rd_valid), .read_addr_o(rd_addr), .read_rdata_o(rd_data),
      .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
      .axi_arid_o(arid), .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst),
      .axi_arlock_o(arlock), .axi_arcache_o(arcache), .axi_arprot_o(arprot), .axi_arqos_o(arqos),
      .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata),
      .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rid_i(rid)
   );

   iob_cache_read_channel_axi #(.BE_DATA_W(256)) dut_w (
      .clk_i(clk), .reset_n(rst_n),
      .replace_valid_i(w_req), .replace_addr_i(w_raddr), .replace_o(w_replace),
      .read_valid_o(w_rd_valid), .read_addr_o(w_rd_addr), .read_rdata_o(w_rd_data),
      .axi_arvalid_o(w_arvalid), .axi_arready_i(w_arready), .axi_araddr_o(w_araddr),
      .axi_arid_o(w_arid), .axi_arlen_o(w_arlen), .axi_arsize_o(w_arsize), .axi_arburst_o(w_arburst),
      .axi_arlock_o(w_arlock), .axi_arcache_o(w_arcache), .axi_arprot_o(w_arprot), .axi_arqos_o(w_arqos),
      .axi_rvalid_i(w_rvalid), .axi_rready_o(w_rready), .axi_rdata_i(w_rdata),
      .axi_rresp_i(w_rresp), .axi_rlast_i(w_rlast), .axi_rid_i(w_rid)
   );

   // Reference behaviour of one line fill on the default DUT: line address a
   // maps to byte address a*32; each burst is 8 beats indexed 0..7; a burst
   // with any non-OKAY response is retried at once with a fresh AR.
   // Ends right after the last beat of the first error-free burst.
   task automatic run_fill(input logic [18:0] a, input int ar_wait, input bit gaps,
                           input int err_beat, input logic [1:0] err_resp,
                           input bit hold_req, input string tag);
      logic [23:0] exp_addr;
      logic [31:0] d;
      int beat, i, wait_n;
      bit first, bad;
      exp_addr = 24'(32'(a) * 32);
      @(negedge clk);
      req = 1'b1; raddr = a; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      #1;
      checks++;
      if (replace !== 1'b0 || arvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s request_cycle: replace=%b arvalid=%b, required 0 0", tag, replace, arvalid);
      end
      first = 1'b1;
      bad   = 1'b1;
      while (bad) begin
         wait_n = first ? ar_wait : 0;
         for (int k = 0; k <= wait_n; k++) begin
            @(negedge clk);
            req = hold_req; arready = (k == wait_n); rvalid = 1'b0; rlast = 1'b0;
            #1;
            checks++;
            if (arvalid !== 1'b1 || araddr !== exp_addr || replace !== 1'b1 || rready !== 1'b0) begin
               errors++;
               $display("FAIL %s ar_phase k=%0d: arvalid=%b araddr=%h replace=%b rready=%b, required 1 %h 1 0",
                        tag, k, arvalid, araddr, replace, rready, exp_addr);
            end
         end
         beat = 0;
         i    = 0;
         bad  = 1'b0;
         while (beat < 8) begin
            @(negedge clk);
            arready = 1'b0;
            if (gaps && (i % 2 == 1)) begin
               rvalid = 1'b0; rlast = 1'b0;
               #1;
               checks++;
               if (rd_valid !== 1'b0 || rready !== 1'b1 || arvalid !== 1'b0) begin
                  errors++;
                  $display("FAIL %s gap: read_valid=%b rready=%b arvalid=%b, required 0 1 0",
                           tag, rd_valid, rready, arvalid);
               end
            end else begin
               d = $urandom;
               rvalid = 1'b1; rdata = d; rlast = (beat == 7);
               rresp = (first && beat == err_beat) ? err_resp : 2'b00;
               if (rresp != 2'b00) bad = 1'b1;
               #1;
               checks++;
               if (rd_valid !== 1'b1 || rd_addr !== 3'(beat) || rd_data !== d ||
                   rready !== 1'b1 || arvalid !== 1'b0 || replace !== 1'b1) begin
                  errors++;
                  $display("FAIL %s beat: valid=%b addr=%0d data=%h rready=%b arvalid=%b replace=%b, required 1 %0d %h 1 0 1",
                           tag, rd_valid, rd_addr, rd_data, rready, arvalid, replace, beat, d);
               end
               beat++;
            end
            i++;
         end
         first = 1'b0;
      end
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      req = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
      #1;
      checks++;
      if (replace !== 1'b0 || arvalid !== 1'b0 || rd_valid !== 1'b0 || rready !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: replace=%b arvalid=%b read_valid=%b rready=%b, required 0 0 0 0",
                  tag, replace, arvalid, rd_valid, rready);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (replace !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || rd_valid !== 1'b0 || araddr !== 24'h0) begin
         errors++;
         $display("FAIL reset_outputs: replace=%b arvalid=%b rready=%b read_valid=%b araddr=%h, required all 0",
                  replace, arvalid, rready, rd_valid, araddr);
      end
      checks++;
      if (arid !== 1'b0 || arlen !== 8'd7 || arsize !== 3'd2 || arburst !== 2'b01) begin
         errors++;
         $display("FAIL reset_desc: arid=%0d arlen=%0d arsize=%0d arburst=%0d, required 0 7 2 1",
                  arid, arlen, arsize, arburst);
      end
      checks++;
      if (arlock !== 1'b0 || arcache !== 4'b0011 || arprot !== 3'b0 || arqos !== 4'b0) begin
         errors++;
         $display("FAIL reset_attr: arlock=%b arcache=%b arprot=%b arqos=%b, required 0 0011 000 0000",
                  arlock, arcache, arprot, arqos);
      end
      checks++;
      if (w_replace !== 1'b0 || w_arlen !== 8'd0 || w_arsize !== 3'd5 || w_rd_addr !== 1'b0) begin
         errors++;
         $display("FAIL reset_wide: replace=%b arlen=%0d arsize=%0d read_addr=%0d, required 0 0 5 0",
                  w_replace, w_arlen, w_arsize, w_rd_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_fill(19'h1234, 0, 1'b0, -1, 2'b00, 1'b0, "basic");
      checks++;
      if (araddr !== 24'h24680) begin
         errors++;
         $display("FAIL basic_araddr: got %h, required 024680", araddr);
      end
      expect_idle("basic");
   endtask

   task automatic test_stall_gaps();
      run_fill(19'($urandom), 5, 1'b1, -1, 2'b00, 1'b0, "stall_gaps");
      expect_idle("stall_gaps");
   endtask

   task automatic test_error_retry();
      run_fill(19'h0abc, 0, 1'b0, 3, 2'b10, 1'b0, "err_beat3");
      expect_idle("err_beat3");
      run_fill(19'h7ffff, 2, 1'b1, 7, 2'b11, 1'b0, "err_last");
      expect_idle("err_last");
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      @(negedge clk);
      req = 1'b1; raddr = 19'h00155;
      @(negedge clk);
      req = 1'b0; arready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         arready = 1'b0; rvalid = 1'b1; d = $urandom; rdata = d; rlast = 1'b0; rresp = 2'b00;
         #1;
         checks++;
         if (rd_valid !== 1'b1 || rd_addr !== 3'(b)) begin
            errors++;
            $display("FAIL mid_reset_pre: valid=%b addr=%0d, required 1 %0d", rd_valid, rd_addr, b);
         end
      end
      @(negedge clk);
      rdata = $urandom;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (replace !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || rd_valid !== 1'b0 ||
          rd_addr !== 3'd0 || rd_data !== 32'h0 || araddr !== 24'h0) begin
         errors++;
         $display("FAIL mid_reset_async: replace=%b arvalid=%b rready=%b valid=%b addr=%0d data=%h araddr=%h, required all 0",
                  replace, arvalid, rready, rd_valid, rd_addr, rd_data, araddr);
      end
      @(negedge clk);
      rvalid = 1'b0;
      rst_n  = 1'b1;
      run_fill(19'h00321, 0, 1'b0, -1, 2'b00, 1'b0, "after_reset");
      expect_idle("after_reset");
   endtask

   task automatic test_back_to_back();
      // request stays high through the first fill; the second one is taken
      // in the first IDLE cycle and shows AR in the following cycle
      run_fill(19'h01111, 1, 1'b1, -1, 2'b00, 1'b1, "b2b_first");
      run_fill(19'h02222, 0, 1'b0, 2, 2'b01, 1'b0, "b2b_second");
      expect_idle("b2b");
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         run_fill(19'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                  2'($urandom_range(1, 3)), 1'b0, "random");
         expect_idle("random");
      end
   endtask

   task automatic test_wide();
      logic [255:0] wd;
      logic [18:0]  a;
      a = 19'($urandom);
      for (int j = 0; j < 8; j++) wd[j*32 +: 32] = $urandom;
      @(negedge clk);
      w_req = 1'b1; w_raddr = a;
      #1;
      checks++;
      if (w_replace !== 1'b0) begin
         errors++;
         $display("FAIL wide_req: replace=%b, required 0", w_replace);
      end
      @(negedge clk);
      w_req = 1'b0; w_arready = 1'b1;
      #1;
      checks++;
      if (w_arvalid !== 1'b1 || w_araddr !== 24'(32'(a) * 32) || w_arlen !== 8'd0 || w_arsize !== 3'd5) begin
         errors++;
         $display("FAIL wide_ar: arvalid=%b araddr=%h arlen=%0d arsize=%0d, required 1 %h 0 5",
                  w_arvalid, w_araddr, w_arlen, w_arsize, 24'(32'(a) * 32));
      end
      @(negedge clk);
      w_arready = 1'b0; w_rvalid = 1'b1; w_rdata = wd; w_rlast = 1'b1; w_rresp = 2'b00;
      #1;
      checks++;
      if (w_rd_valid !== 1'b1 || w_rd_addr !== 1'b0 || w_rd_data !== wd) begin
         errors++;
         $display("FAIL wide_beat: valid=%b addr=%0d data_ok=%b, required 1 0 1",
                  w_rd_valid, w_rd_addr, (w_rd_data === wd));
      end
      @(negedge clk);
      w_rvalid = 1'b0; w_rlast = 1'b0;
      #1;
      checks++;
      if (w_replace !== 1'b0 || w_rready !== 1'b0) begin
         errors++;
         $display("FAIL wide_done: replace=%b rready=%b, required 0 0", w_replace, w_rready);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      req = 1'b0; raddr = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
      w_req = 1'b0; w_raddr = '0; w_arready = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_rresp = '0;
      w_rlast = 1'b0; w_rid = '0;
      test_reset();
      test_basic();
      test_stall_gaps();
      test_error_retry();
      test_mid_reset();
      test_back_to_back();
      test_wide();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
